// File: rtl/ex_wb_dest_pipe.sv
// ============================================================================
//  Module      : ex_wb_dest_pipe
//  Description : EX/MEM and MEM/WB destination/write-back pipeline registers
//                with register-file write port and EX operand-forward selects.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_wb_dest_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_dest_reg,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_valid,
    output logic [REG_ADDR_W-1:0] mem_dest_reg,
    output logic                  mem_reg_write,
    output logic                  mem_mem_to_reg,
    output logic [DATA_W-1:0]     mem_alu_result,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_dest_reg,
    output logic                  wb_reg_write,
    output logic [DATA_W-1:0]     wb_data,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic [REG_ADDR_W-1:0] c_REG_ZERO  = '0;
    localparam logic [1:0]            c_FWD_NONE  = 2'b00;
    localparam logic [1:0]            c_FWD_WB    = 2'b01;
    localparam logic [1:0]            c_FWD_MEM   = 2'b10;
    localparam logic [1:0]            c_FWD_LOAD  = 2'b11;

    logic                  w_we_ex;
    logic                  w_ex_take;

    logic                  mem_valid_q,      mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_dest_reg_q,   mem_dest_reg_d;
    logic                  mem_reg_write_q,  mem_reg_write_d;
    logic                  mem_mem_to_reg_q, mem_mem_to_reg_d;
    logic [DATA_W-1:0]     mem_alu_result_q, mem_alu_result_d;

    logic                  wb_valid_q,       wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_dest_reg_q,    wb_dest_reg_d;
    logic                  wb_reg_write_q,   wb_reg_write_d;
    logic [DATA_W-1:0]     wb_data_q,        wb_data_d;

    // r0 is hard-wired zero, so an instruction targeting it never writes.
    assign w_we_ex   = ex_valid & ex_reg_write & (ex_dest_reg != c_REG_ZERO);
    assign w_ex_take = ex_valid & ~flush;

    always_comb begin
        mem_valid_d      = mem_valid_q;
        mem_dest_reg_d   = mem_dest_reg_q;
        mem_reg_write_d  = mem_reg_write_q;
        mem_mem_to_reg_d = mem_mem_to_reg_q;
        mem_alu_result_d = mem_alu_result_q;
        if (!hold) begin
            if (w_ex_take) begin
                mem_valid_d      = ex_valid;
                mem_dest_reg_d   = ex_dest_reg;
                mem_reg_write_d  = w_we_ex;
                mem_mem_to_reg_d = ex_mem_to_reg & ex_valid;
                mem_alu_result_d = ex_alu_result;
            end else begin
                mem_valid_d      = 1'b0;
                mem_dest_reg_d   = c_REG_ZERO;
                mem_reg_write_d  = 1'b0;
                mem_mem_to_reg_d = 1'b0;
                mem_alu_result_d = '0;
            end
        end
    end

    always_comb begin
        wb_valid_d     = wb_valid_q;
        wb_dest_reg_d  = wb_dest_reg_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_data_d      = wb_data_q;
        if (!hold) begin
            wb_valid_d     = mem_valid_q;
            wb_dest_reg_d  = mem_dest_reg_q;
            wb_reg_write_d = mem_reg_write_q;
            wb_data_d      = mem_mem_to_reg_q ? mem_rdata : mem_alu_result_q;
        end
    end

    // Reset beats hold: a stalled pipe still clears on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q      <= 1'b0;
            mem_dest_reg_q   <= c_REG_ZERO;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_alu_result_q <= '0;
            wb_valid_q       <= 1'b0;
            wb_dest_reg_q    <= c_REG_ZERO;
            wb_reg_write_q   <= 1'b0;
            wb_data_q        <= '0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_dest_reg_q   <= mem_dest_reg_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_alu_result_q <= mem_alu_result_d;
            wb_valid_q       <= wb_valid_d;
            wb_dest_reg_q    <= wb_dest_reg_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_data_q        <= wb_data_d;
        end
    end

    // EX/MEM is checked first so the newest producer of a register wins.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  m_we,
        input logic                  m_ld,
        input logic [REG_ADDR_W-1:0] m_dst,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_dst
    );
        logic [1:0] sel;
        sel = c_FWD_NONE;
        if (src != c_REG_ZERO) begin
            if (m_we && (m_dst == src)) begin
                sel = m_ld ? c_FWD_LOAD : c_FWD_MEM;
            end else if (w_we && (w_dst == src)) begin
                sel = c_FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_reg_write_q, mem_mem_to_reg_q, mem_dest_reg_q,
                        wb_reg_write_q, wb_dest_reg_q);
        fwd_b = fwd_sel(ex_rt, mem_reg_write_q, mem_mem_to_reg_q, mem_dest_reg_q,
                        wb_reg_write_q, wb_dest_reg_q);
    end

    assign mem_valid      = mem_valid_q;
    assign mem_dest_reg   = mem_dest_reg_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_to_reg = mem_mem_to_reg_q;
    assign mem_alu_result = mem_alu_result_q;
    assign wb_valid       = wb_valid_q;
    assign wb_dest_reg    = wb_dest_reg_q;
    assign wb_reg_write   = wb_reg_write_q;
    assign wb_data        = wb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_wb_dest_pipe.sv
// ============================================================================
//  Module      : tb_ex_wb_dest_pipe
//  Description : Self-checking bench for ex_wb_dest_pipe (model + directed).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_wb_dest_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_dest_reg = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_to_reg = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [4:0]  ex_rs = '0;
    logic [4:0]  ex_rt = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid, mem_reg_write, mem_mem_to_reg;
    logic [4:0]  mem_dest_reg;
    logic [31:0] mem_alu_result;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_dest_reg;
    logic [31:0] wb_data;
    logic [1:0]  fwd_a, fwd_b;

    ex_wb_dest_pipe #(.REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_dest_reg(ex_dest_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_result(ex_alu_result), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_dest_reg(mem_dest_reg),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_alu_result(mem_alu_result),
        .wb_valid(wb_valid), .wb_dest_reg(wb_dest_reg),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    // Model: an in-flight instruction record per stage.
    typedef struct {
        logic        valid;
        logic [4:0]  dest;
        logic        writes;
        logic        is_load;
        logic [31:0] value;
    } slot_t;

    slot_t m_mem = '{1'b0, 5'd0, 1'b0, 1'b0, 32'd0};
    slot_t m_wb  = '{1'b0, 5'd0, 1'b0, 1'b0, 32'd0};

    int n_total = 0;
    int n_pass  = 0;
    int n_hazard = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) begin
        slot_t nm;
        if (rst) begin
            m_mem = '{1'b0, 5'd0, 1'b0, 1'b0, 32'd0};
            m_wb  = '{1'b0, 5'd0, 1'b0, 1'b0, 32'd0};
        end else if (!hold) begin
            m_wb.valid   = m_mem.valid;
            m_wb.dest    = m_mem.dest;
            m_wb.writes  = m_mem.writes;
            m_wb.is_load = 1'b0;
            m_wb.value   = m_mem.is_load ? mem_rdata : m_mem.value;
            if (flush || !ex_valid) begin
                nm = '{1'b0, 5'd0, 1'b0, 1'b0, 32'd0};
            end else begin
                nm.valid   = 1'b1;
                nm.dest    = ex_dest_reg;
                nm.writes  = ex_reg_write && (ex_dest_reg != 5'd0);
                nm.is_load = ex_mem_to_reg;
                nm.value   = ex_alu_result;
            end
            m_mem = nm;
        end
    end

    function automatic logic [1:0] model_fwd(input logic [4:0] s);
        if (s == 5'd0) return 2'b00;
        if (m_mem.writes && m_mem.dest == s) return m_mem.is_load ? 2'b11 : 2'b10;
        if (m_wb.writes && m_wb.dest == s) return 2'b01;
        return 2'b00;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("mem_valid",      {31'd0, mem_valid},      {31'd0, m_mem.valid});
            cmp("mem_dest_reg",   {27'd0, mem_dest_reg},   {27'd0, m_mem.dest});
            cmp("mem_reg_write",  {31'd0, mem_reg_write},  {31'd0, m_mem.writes});
            cmp("mem_mem_to_reg", {31'd0, mem_mem_to_reg}, {31'd0, m_mem.is_load});
            cmp("mem_alu_result", mem_alu_result,          m_mem.value);
            cmp("wb_valid",       {31'd0, wb_valid},       {31'd0, m_wb.valid});
            cmp("wb_dest_reg",    {27'd0, wb_dest_reg},    {27'd0, m_wb.dest});
            cmp("wb_reg_write",   {31'd0, wb_reg_write},   {31'd0, m_wb.writes});
            cmp("wb_data",        wb_data,                 m_wb.value);
            cmp("fwd_a",          {30'd0, fwd_a},          {30'd0, model_fwd(ex_rs)});
            cmp("fwd_b",          {30'd0, fwd_b},          {30'd0, model_fwd(ex_rt)});
            if (model_fwd(ex_rs) == 2'b11 || model_fwd(ex_rt) == 2'b11) n_hazard++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic v, input logic [4:0] d, input logic w, input logic l,
                       input logic [31:0] alu, input logic [4:0] rs, input logic [4:0] rt);
        ex_valid = v; ex_dest_reg = d; ex_reg_write = w; ex_mem_to_reg = l;
        ex_alu_result = alu; ex_rs = rs; ex_rt = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        cmp("rst mem_valid", {31'd0, mem_valid}, 32'd0);
        cmp("rst wb_valid",  {31'd0, wb_valid},  32'd0);
        cmp("rst wb_data",   wb_data,            32'd0);
        cmp("rst fwd_a",     {30'd0, fwd_a},     32'd0);
        cmp("rst fwd_b",     {30'd0, fwd_b},     32'd0);

        // ALU op to r8
        drv(1, 5'd8, 1, 0, 32'h0000_1234, 5'd0, 5'd0);
        tick();
        drv(0, 5'd0, 0, 0, 32'd0, 5'd0, 5'd0);
        cmp("alu mem_dest",  {27'd0, mem_dest_reg}, 32'd8);
        cmp("alu mem_we",    {31'd0, mem_reg_write}, 32'd1);
        cmp("alu mem_res",   mem_alu_result, 32'h1234);
        tick();
        cmp("alu wb_dest",   {27'd0, wb_dest_reg}, 32'd8);
        cmp("alu wb_we",     {31'd0, wb_reg_write}, 32'd1);
        cmp("alu wb_data",   wb_data, 32'h1234);

        // Load to r9, consumer in EX while load is in MEM
        drv(1, 5'd9, 1, 1, 32'h0000_0100, 5'd0, 5'd0);
        tick();
        drv(0, 5'd0, 0, 0, 32'd0, 5'd9, 5'd0);
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        cmp("load fwd_a", {30'd0, fwd_a}, 32'd3);
        $display("note: load-use hazard visible on fwd_a (expected in this directed case)");
        tick();
        mem_rdata = 32'h0;
        cmp("load wb_data", wb_data, 32'hDEAD_BEEF);
        cmp("load wb_dest", {27'd0, wb_dest_reg}, 32'd9);

        // Forward priority on r5
        drv(1, 5'd5, 1, 0, 32'h11, 5'd0, 5'd0);
        tick();
        drv(1, 5'd5, 1, 0, 32'h22, 5'd0, 5'd0);
        tick();
        drv(1, 5'd0, 0, 0, 32'h0, 5'd5, 5'd5);
        #1;
        cmp("prio fwd_a", {30'd0, fwd_a}, 32'd2);
        cmp("prio fwd_b", {30'd0, fwd_b}, 32'd2);
        tick();
        drv(0, 5'd0, 0, 0, 32'h0, 5'd5, 5'd5);
        #1;
        cmp("old fwd_a", {30'd0, fwd_a}, 32'd1);
        cmp("old wb_data", wb_data, 32'h22);

        // Write to r0 is suppressed
        drv(1, 5'd0, 1, 0, 32'h55, 5'd0, 5'd0);
        tick();
        drv(0, 5'd0, 0, 0, 32'h0, 5'd0, 5'd0);
        cmp("r0 mem_we", {31'd0, mem_reg_write}, 32'd0);
        tick();
        cmp("r0 wb_we", {31'd0, wb_reg_write}, 32'd0);
        cmp("r0 fwd_a", {30'd0, fwd_a}, 32'd0);

        // Hold with flush, then release with flush still high
        drv(1, 5'd7, 1, 0, 32'h77, 5'd0, 5'd0);
        tick();
        hold = 1'b1; flush = 1'b1;
        drv(1, 5'd3, 1, 0, 32'h33, 5'd7, 5'd0);
        tick(); tick(); tick();
        cmp("hold mem_dest", {27'd0, mem_dest_reg}, 32'd7);
        cmp("hold mem_res",  mem_alu_result, 32'h77);
        cmp("hold fwd_a",    {30'd0, fwd_a}, 32'd2);
        hold = 1'b0;
        tick();
        flush = 1'b0;
        drv(0, 5'd0, 0, 0, 32'h0, 5'd0, 5'd0);
        cmp("flush mem_valid", {31'd0, mem_valid}, 32'd0);
        cmp("flush wb_dest",   {27'd0, wb_dest_reg}, 32'd7);
        cmp("flush wb_data",   wb_data, 32'h77);

        // Reset while holding
        drv(1, 5'd4, 1, 0, 32'h44, 5'd0, 5'd0);
        tick();
        tick();
        hold = 1'b1; rst = 1'b1;
        tick();
        hold = 1'b0; rst = 1'b0;
        drv(0, 5'd0, 0, 0, 32'h0, 5'd0, 5'd0);
        cmp("rsthold mem_valid", {31'd0, mem_valid}, 32'd0);
        cmp("rsthold wb_valid",  {31'd0, wb_valid},  32'd0);
        cmp("rsthold wb_data",   wb_data,            32'd0);

        // Mixed traffic on a small register set
        for (int i = 0; i < 60; i++) begin
            drv(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), $urandom, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)));
            mem_rdata = $urandom;
            hold  = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
        end
        hold = 1'b0; flush = 1'b0;
        drv(0, 5'd0, 0, 0, 32'h0, 5'd0, 5'd0);
        tick();

        $display("load-use selects observed: %0d", n_hazard);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_wb_dest_pipe.md
Name: ex_wb_dest_pipe

Overview:
- Carries the selected 5-bit destination register (output of the RegDst 2:1 mux in EX) plus write-back control and data through the EX/MEM and MEM/WB pipeline registers.
- Produces the register-file write port (wb_*).
- Produces operand-forwarding selects for the EX stage.
- Sits directly downstream of the destination-register mux and upstream of the register file.

Parameters:
- REG_ADDR_W, 5, register address width.
- DATA_W, 32, datapath width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  freeze both pipeline registers (memory wait).
- flush  input  1  replace incoming EX entry with a bubble.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_dest_reg  input  REG_ADDR_W  destination register from the RegDst mux.
- ex_reg_write  input  1  instruction writes the register file.
- ex_mem_to_reg  input  1  instruction is a load.
- ex_alu_result  input  DATA_W  ALU result or memory address.
- ex_rs  input  REG_ADDR_W  source operand A register of the instruction in EX.
- ex_rt  input  REG_ADDR_W  source operand B register of the instruction in EX.
- mem_rdata  input  DATA_W  data memory read data, combinational in the MEM stage.
- mem_valid  output  1  EX/MEM entry valid.
- mem_dest_reg  output  REG_ADDR_W  EX/MEM destination.
- mem_reg_write  output  1  EX/MEM write enable.
- mem_mem_to_reg  output  1  EX/MEM load flag.
- mem_alu_result  output  DATA_W  EX/MEM ALU result; drives the memory address.
- wb_valid  output  1  MEM/WB entry valid.
- wb_dest_reg  output  REG_ADDR_W  register-file write address.
- wb_reg_write  output  1  register-file write enable.
- wb_data  output  DATA_W  register-file write data.
- fwd_a  output  2  forward select for operand A.
- fwd_b  output  2  forward select for operand B.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset: all registered outputs go to 0 on the edge where rst=1. rst has priority over hold and flush, including mid-stall.
- Effective write enable: we_ex = ex_valid & ex_reg_write & (ex_dest_reg != 0). Register 0 is never written or forwarded.
- EX/MEM register, when hold=0:
  - If flush=1 or ex_valid=0: load a bubble (valid=0, reg_write=0, mem_to_reg=0, dest=0, alu_result=0).
  - Otherwise: capture ex_valid, ex_dest_reg, we_ex, ex_mem_to_reg & ex_valid, ex_alu_result.
- MEM/WB register, when hold=0:
  - wb_valid <= mem_valid.
  - wb_dest_reg <= mem_dest_reg.
  - wb_reg_write <= mem_reg_write.
  - wb_data <= mem_mem_to_reg ? mem_rdata : mem_alu_result.
- hold=1: both registers retain their values. flush is ignored during hold; the controller keeps flush asserted until hold deasserts.
- Latency: an EX instruction appears on mem_* 1 cycle later and on wb_* 2 cycles later, plus any hold cycles.
- Forwarding (combinational on registered state plus ex_rs/ex_rt). Evaluated per operand s in {ex_rs, ex_rt}, first match wins:
  - 2'b11: mem_reg_write & mem_mem_to_reg & mem_dest_reg==s, s!=0. This is a load-use hazard; upstream guarantees it never occurs, and the bench flags it.
  - 2'b10: mem_reg_write & !mem_mem_to_reg & mem_dest_reg==s, s!=0. Forward mem_alu_result.
  - 2'b01: wb_reg_write & wb_dest_reg==s, s!=0. Forward wb_data.
  - 2'b00: no forwarding.
- Priority: when both EX/MEM and MEM/WB match, EX/MEM (the newer value) wins.
- Forwarding outputs stay valid during hold; they reflect the frozen state.
- No X on any output after reset. wb_data is fully defined even when wb_reg_write=0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, ex_valid=0 -> all mem_*/wb_* = 0, fwd_a=fwd_b=00.
- ALU op: ex_dest_reg=8, reg_write=1, alu_result=0x0000_1234 -> mem_* match at cycle+1; wb_dest_reg=8, wb_reg_write=1, wb_data=0x1234 at cycle+2.
- Load: ex_mem_to_reg=1, dest=9, mem_rdata=0xDEAD_BEEF during MEM -> wb_data=0xDEADBEEF, wb_dest_reg=9. With ex_rs=9 while the load is in MEM -> fwd_a=11.
- Forward priority: back-to-back writes to r5 (0x11 then 0x22), next instruction ex_rs=ex_rt=5 -> fwd_a=fwd_b=10. With only the older write in WB -> 01. dest=0 with reg_write=1 -> wb_reg_write=0, fwd=00.
- Hold/flush: hold=1 for 3 cycles with flush=1 -> registers frozen. Hold drops with flush still 1 -> bubble enters EX/MEM, mem_valid=0.
- Reset mid-hold: hold=1 and rst=1 on the same edge -> all outputs 0 on the next cycle.
